// File: rtl/led_ind_multi_if.sv
// Mode/activity inputs and LED/tick outputs of the multi-channel LED driver.
// The strobe is named evt because event is a reserved word in SystemVerilog.
interface led_ind_multi_if #(
  parameter int N_CH = 4
);
  logic [2*N_CH-1:0] mode;
  logic [N_CH-1:0]   evt;
  logic [N_CH-1:0]   led;
  logic              tick_ms;

  modport master (output mode, evt, input led, tick_ms);
  modport slave  (input mode, evt, output led, tick_ms);
endinterface

// File: rtl/led_ind_multi.sv
// Multi-channel LED driver: off / on / shared blink / activity pulse-stretch per channel.
// Also exports the 1 ms tick that paces both the blink and the stretch timers.
module led_ind_multi #(
  parameter int P_CLK_FREQ_HZ   = 50_000_000,
  parameter int P_N_CH          = 4,
  parameter int P_BLINK_HALF_MS = 500,
  parameter int P_STRETCH_MS    = 50
) (
  input  logic           clk,
  input  logic           rst_n,
  led_ind_multi_if.slave bus
);

  localparam int N_CYC_MS = P_CLK_FREQ_HZ / 1000;
  localparam int PRE_W    = (N_CYC_MS > 1) ? $clog2(N_CYC_MS) : 1;
  localparam int BLINK_W  = (P_BLINK_HALF_MS > 1) ? $clog2(P_BLINK_HALF_MS) : 1;
  localparam int ACT_W    = $clog2(P_STRETCH_MS + 1);

  localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(N_CYC_MS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(P_BLINK_HALF_MS - 1);
  localparam logic [ACT_W-1:0]   ACT_LOAD   = ACT_W'(P_STRETCH_MS);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_ACT   = 2'b11
  } mode_e;

  logic [PRE_W-1:0]   pre_cnt;
  logic               tick_q;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [ACT_W-1:0]   act_cnt [P_N_CH];
  logic [P_N_CH-1:0]  act_busy;
  logic [P_N_CH-1:0]  led_d;
  logic [P_N_CH-1:0]  led_q;

  // 1 ms prescaler; tick_q is registered so it is high for the clk after the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      tick_q  <= 1'b0;
    end else begin
      // NOTE: state updates use <= so every flop samples pre-edge values regardless of statement order.
      tick_q <= (pre_cnt == PRE_LAST);
      if (pre_cnt == PRE_LAST) pre_cnt <= '0;
      else                     pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Shared blink timebase: every blink channel follows one phase, so they stay in step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick_q) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Activity counters run in every mode so switching into activity shows in-flight events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these are a handful of flops, not a RAM, so clearing every entry in reset is cheap and wanted.
      for (int i = 0; i < P_N_CH; i++) act_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < P_N_CH; i++) begin
        if (bus.evt[i])                    act_cnt[i] <= ACT_LOAD;
        else if (tick_q && act_busy[i])    act_cnt[i] <= act_cnt[i] - ACT_W'(1);
      end
    end
  end

  always_comb begin
    act_busy = '0;
    for (int i = 0; i < P_N_CH; i++) act_busy[i] = (act_cnt[i] != '0);
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves led_d unassigned and infers a latch.
    led_d = '0;
    for (int i = 0; i < P_N_CH; i++) begin
      case (mode_e'(bus.mode[2*i +: 2]))
        MODE_OFF:   led_d[i] = 1'b0;
        MODE_ON:    led_d[i] = 1'b1;
        MODE_BLINK: led_d[i] = blink_phase;
        MODE_ACT:   led_d[i] = act_busy[i] | bus.evt[i];
        default:    led_d[i] = 1'b0;
      endcase
    end
  end

  // LED pins come straight from flops, so mode changes cannot glitch them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= '0;
    else        led_q <= led_d;
  end

  assign bus.led     = led_q;
  assign bus.tick_ms = tick_q;

endmodule
